// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared immediate format encoding, range limits and buffer states
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_U = 3'b011,
        FMT_J = 3'b100
    } imm_fmt_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;
    localparam int IMM21_MIN = -1048576;
    localparam int IMM21_MAX = 1048574;

    // Instruction bits owned by each format's immediate field
    localparam logic [31:0] MASK_I  = 32'hFFF0_0000;
    localparam logic [31:0] MASK_SB = 32'hFE00_0F80;
    localparam logic [31:0] MASK_UJ = 32'hFFFF_F000;

    function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/skid_buf.sv
// rtl/skid_buf.sv - two-entry valid/ready buffer: output register plus one skid register
module skid_buf
    import imm_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_t   state_q, state_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic         push, pop;

    assign push      = in_valid && in_ready_q;
    assign pop       = (state_q != BUF_EMPTY) && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = out_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    out_d   = in_data;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                case ({push, pop})
                    2'b10: begin
                        skid_d  = in_data;
                        state_d = BUF_TWO;
                    end
                    2'b01: state_d = BUF_EMPTY;
                    2'b11: out_d = in_data;
                    default: ;
                endcase
            end
            BUF_TWO: begin
                if (pop) begin
                    out_d   = skid_q;
                    state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        // Registered ready: derived from next state so no path from out_ready reaches in_ready
        in_ready_d = (state_d != BUF_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BUF_EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/imm_packer.sv
// rtl/imm_packer.sv - places a signed immediate into an RV32I word, range-checks it, and streams the result
module imm_packer
    import imm_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_sel,
    input  logic [DATA_W-1:0]    in_imm,
    input  logic [DATA_W-1:0]    in_base,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic signed [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0]        imm_bits;
    logic [DATA_W-1:0]        imm_mask;
    logic [DATA_W-1:0]        enc_instr;
    logic                     enc_err;
    logic                     enc_legal;
    logic                     accept;
    logic [DATA_W:0]          buf_data;
    logic [ERR_CNT_W-1:0]     err_count_q, err_count_d;

    assign imm_s = in_imm;

    always_comb begin
        imm_bits  = '0;
        imm_mask  = '0;
        enc_err   = 1'b1;
        enc_legal = 1'b1;
        case (in_sel)
            FMT_I: begin
                imm_mask = MASK_I;
                imm_bits = {in_imm[11:0], 20'b0};
                enc_err  = !in_range(imm_s, IMM12_MIN, IMM12_MAX);
            end
            FMT_S: begin
                imm_mask = MASK_SB;
                imm_bits = {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0};
                enc_err  = !in_range(imm_s, IMM12_MIN, IMM12_MAX);
            end
            FMT_B: begin
                imm_mask = MASK_SB;
                imm_bits = {in_imm[12], in_imm[10:5], 13'b0, in_imm[4:1], in_imm[11], 7'b0};
                enc_err  = !in_range(imm_s, IMM13_MIN, IMM13_MAX) || in_imm[0];
            end
            FMT_U: begin
                imm_mask = MASK_UJ;
                imm_bits = {in_imm[31:12], 12'b0};
                enc_err  = (in_imm[11:0] != 12'b0);
            end
            FMT_J: begin
                imm_mask = MASK_UJ;
                imm_bits = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'b0};
                enc_err  = !in_range(imm_s, IMM21_MIN, IMM21_MAX) || in_imm[0];
            end
            default: enc_legal = 1'b0;
        endcase
        // Out-of-range immediates still produce the truncated word; only illegal formats zero it
        enc_instr = enc_legal ? ((in_base & ~imm_mask) | imm_bits) : '0;
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        err_count_d = err_count_q;
        if (accept && enc_err && (err_count_q != {ERR_CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;

    skid_buf #(
        .W (DATA_W + 1)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({enc_err, enc_instr}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_data)
    );

    assign out_err   = buf_data[DATA_W];
    assign out_instr = buf_data[DATA_W-1:0];

endmodule
